instr_issue: RTL and testbench

//  Instruction fetch/issue front end for the four-stage ALU/memory pipeline.

---
 rtl/instr_issue.sv | 232 +++++++++++++++++++++++
 tb/tb_instr_issue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue.sv
// Instruction fetch/issue front end. Fetches 24-bit words, holds the word
// under decision in IR, and issues it to the pipeline's stage-1 operand
// fields. The pipeline has no forwarding, so RAW hazards against the last
// HAZARD_DEPTH issues are covered here by inserting bubbles.
//
// Issue handshake: issue_valid qualifies func/rd/rs1/rs2/addr for exactly
// one cycle. There is no ready; the pipeline accepts every cycle. When
// issue_valid is 0 all operand fields are driven to 0.
module instr_issue #(
  parameter int         HAZARD_DEPTH = 2,
  parameter logic [3:0] HALT_FUNC    = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  base_addr,
  output logic        imem_rd,
  output logic [7:0]  imem_addr,
  input  logic [23:0] imem_data,
  output logic [3:0]  func,
  output logic [3:0]  rd,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [7:0]  addr,
  output logic        issue_valid,
  output logic        busy,
  output logic        done,
  output logic [7:0]  stall_cnt,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    RUN   = 3'd2,
    STALL = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] FUNC_NEGA = 4'd2;

  state_t      state, state_n;
  logic [7:0]  pc, pc_n;
  logic [7:0]  base_q, base_n;
  logic [23:0] ir, ir_n;
  logic        ir_vld, ir_vld_n;      // IR holds a fetched word
  logic        fetch_end, fetch_end_n; // 256 words fetched, stop fetching
  logic        ir_last, ir_last_n;    // IR holds the final fetched word
  logic        imem_rd_n;
  logic [7:0]  imem_addr_n;
  logic        issue_n;
  logic [23:0] word_q, word_n;
  logic        busy_n;
  logic        done_n;
  logic [7:0]  stall_cnt_n;

  // Scoreboard of in-flight destinations, entry 0 is the most recent issue.
  logic [HAZARD_DEPTH-1:0] sb_vld;
  logic [3:0]              sb_rd [HAZARD_DEPTH];
  logic                    sb_shift, sb_clr, sb_in_vld;

  logic [3:0] ir_func, ir_rd, ir_rs1, ir_rs2;
  logic       hazard;
  logic       bus_halt;
  logic       capture;

  assign ir_func  = ir[23:20];
  assign ir_rd    = ir[19:16];
  assign ir_rs1   = ir[15:12];
  assign ir_rs2   = ir[11:8];
  assign bus_halt = (imem_data[23:20] == HALT_FUNC);

  assign func        = word_q[23:20];
  assign rd          = word_q[19:16];
  assign rs1         = word_q[15:12];
  assign rs2         = word_q[11:8];
  assign addr        = word_q[7:0];
  assign dbg_state   = state;

  // RAW check of IR sources against every valid in-flight destination.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZARD_DEPTH; i++) begin
      if (sb_vld[i] && ((sb_rd[i] == ir_rs1) ||
                        ((ir_func != FUNC_NEGA) && (sb_rd[i] == ir_rs2))))
        hazard = 1'b1;
    end
  end

  // Next-state and next-output decisions; capture loads IR and fetches ahead.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    base_n      = base_q;
    ir_n        = ir;
    ir_vld_n    = ir_vld;
    fetch_end_n = fetch_end;
    ir_last_n   = ir_last;
    imem_rd_n   = 1'b0;
    imem_addr_n = imem_addr;
    issue_n     = 1'b0;
    word_n      = 24'h0;
    busy_n      = busy;
    done_n      = 1'b0;
    stall_cnt_n = stall_cnt;
    sb_shift    = 1'b0;
    sb_clr      = 1'b0;
    sb_in_vld   = 1'b0;
    capture     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n     = PRIME;
          pc_n        = base_addr;
          base_n      = base_addr;
          stall_cnt_n = 8'h00;
          busy_n      = 1'b1;
          ir_vld_n    = 1'b0;
          fetch_end_n = 1'b0;
          ir_last_n   = 1'b0;
          sb_clr      = 1'b1;
        end
      end
      PRIME: begin
        imem_rd_n   = 1'b1;
        imem_addr_n = pc;
        pc_n        = pc + 8'd1;
        state_n     = RUN;
      end
      RUN, STALL: begin
        sb_shift = 1'b1;
        if (!ir_vld) begin
          capture = 1'b1;
          state_n = RUN;
        end else if (ir_func == HALT_FUNC) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else if (hazard) begin
          state_n = STALL;
          if (stall_cnt != 8'hFF)
            stall_cnt_n = stall_cnt + 8'd1;
        end else begin
          issue_n   = 1'b1;
          word_n    = ir;
          sb_in_vld = 1'b1;
          if (ir_last) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            capture = 1'b1;
            state_n = RUN;
          end
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Fetch ahead unless the pc has come back to base or the next word halts.
    if (capture) begin
      ir_n     = imem_data;
      ir_vld_n = 1'b1;
      if (fetch_end) begin
        ir_last_n = 1'b1;
      end else if (!bus_halt) begin
        imem_rd_n   = 1'b1;
        imem_addr_n = pc;
        pc_n        = pc + 8'd1;
        if ((pc + 8'd1) == base_q)
          fetch_end_n = 1'b1;
      end
    end
  end

  // State, pc, IR and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= 8'h00;
      base_q      <= 8'h00;
      ir          <= 24'h0;
      ir_vld      <= 1'b0;
      fetch_end   <= 1'b0;
      ir_last     <= 1'b0;
      imem_rd     <= 1'b0;
      imem_addr   <= 8'h00;
      issue_valid <= 1'b0;
      word_q      <= 24'h0;
      busy        <= 1'b0;
      done        <= 1'b0;
      stall_cnt   <= 8'h00;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      base_q      <= base_n;
      ir          <= ir_n;
      ir_vld      <= ir_vld_n;
      fetch_end   <= fetch_end_n;
      ir_last     <= ir_last_n;
      imem_rd     <= imem_rd_n;
      imem_addr   <= imem_addr_n;
      issue_valid <= issue_n;
      word_q      <= word_n;
      busy        <= busy_n;
      done        <= done_n;
      stall_cnt   <= stall_cnt_n;
    end
  end

  // Scoreboard shift: an issue enters {1,rd}, a bubble enters {0,0}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_vld <= '0;
      for (int i = 0; i < HAZARD_DEPTH; i++) sb_rd[i] <= 4'h0;
    end else if (sb_clr) begin
      sb_vld <= '0;
      for (int i = 0; i < HAZARD_DEPTH; i++) sb_rd[i] <= 4'h0;
    end else if (sb_shift) begin
      for (int i = HAZARD_DEPTH - 1; i > 0; i--) begin
        sb_vld[i] <= sb_vld[i-1];
        sb_rd[i]  <= sb_rd[i-1];
      end
      sb_vld[0] <= sb_in_vld;
      sb_rd[0]  <= sb_in_vld ? ir_rd : 4'h0;
    end
  end

endmodule

// File: tb/tb_instr_issue.sv
// Bench for instr_issue: program memory model, issue scoreboard, run tasks.
module tb_instr_issue;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic        imem_rd;
  logic [7:0]  imem_addr;
  logic [23:0] imem_data;
  logic [3:0]  func, rd, rs1, rs2;
  logic [7:0]  addr;
  logic        issue_valid, busy, done;
  logic [7:0]  stall_cnt;
  logic [2:0]  dbg_state;

  instr_issue dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
    .func(func), .rd(rd), .rs1(rs1), .rs2(rs2), .addr(addr),
    .issue_valid(issue_valid), .busy(busy), .done(done),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  logic [23:0] mem [256];
  logic [23:0] rdata = 24'h0;
  assign imem_data = rdata;

  // ---------------- scoreboard state ----------------
  logic [23:0] exp_q[$];
  logic [7:0]  fetch_log[$];
  int n_checks = 0;
  int n_err = 0;
  int first_cyc, last_cyc, done_cyc, done_cnt, bubble_bad, t0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] ins(input logic [3:0] f, input logic [3:0] d,
                                      input logic [3:0] s1, input logic [3:0] s2,
                                      input logic [7:0] a);
    return {f, d, s1, s2, a};
  endfunction

  // Load a word; every non-halt word of the program is an expected issue.
  task automatic put(input logic [7:0] a, input logic [23:0] w);
    mem[a] = w;
    if (w[23:20] != 4'hF) exp_q.push_back(w);
  endtask

  // Memory returns data for the strobed address mid-cycle; monitor issues.
  always @(negedge clk) begin
    logic [23:0] got;
    logic [23:0] e;
    if (rst_n) begin
      if (imem_rd) begin
        rdata = mem[imem_addr];
        fetch_log.push_back(imem_addr);
      end
      got = {func, rd, rs1, rs2, addr};
      if (issue_valid) begin
        if (exp_q.size() == 0) begin
          check("issue_extra", {8'h0, got}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("issue", {8'h0, got}, {8'h0, e});
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end else if (got != 24'h0) begin
        bubble_bad++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run(input string tag, input logic [7:0] base, input int exp_stall,
                     input bit mid_start);
    first_cyc = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0; bubble_bad = 0;
    fetch_log.delete();
    @(posedge clk); #1;
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    t0 = cyc; start = 1'b0; base_addr = 8'h00;
    for (int i = 0; i < 600 && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      if (mid_start && i == 3) begin start = 1'b1; base_addr = 8'h40; end
      else begin start = 1'b0; base_addr = 8'h00; end
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_busy"}, {31'h0, busy}, 0);
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_stall"}, {24'h0, stall_cnt}, exp_stall);
    check({tag, "_lat"}, first_cyc - t0, 3);
    check({tag, "_bubble0"}, bubble_bad, 0);
  endtask

  task automatic check_fetch(input string tag, input logic [7:0] b, input int n);
    check({tag, "_nfetch"}, fetch_log.size(), n);
    for (int i = 0; i < n && i < fetch_log.size(); i++)
      check({tag, "_fetch"}, {24'h0, fetch_log[i]}, {24'h0, b + 8'(i)});
  endtask

  // ---------------- tests ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 24'hF00000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {28'h0, issue_valid, busy, done, imem_rd}, 0);
    check("rst_data", {8'h0, func, rd, rs1, rs2, addr}, 0);
    check("rst_pc_cnt", {16'h0, imem_addr, stall_cnt}, 0);
    check("rst_state", {29'h0, dbg_state}, 0);
    rst_n = 1'b1;

    // 1: independent add/sub/nega then halt
    put(8'h10, ins(4'h0, 4'd1, 4'd2, 4'd3, 8'h11));
    put(8'h11, ins(4'h1, 4'd4, 4'd5, 4'd6, 8'h22));
    put(8'h12, ins(4'h2, 4'd7, 4'd8, 4'd9, 8'h33));
    put(8'h13, 24'hF00000);
    run("t1", 8'h10, 0, 1'b0);
    check("t1_last", last_cyc - t0, 5);
    check("t1_donecyc", done_cyc - t0, 6);
    check_fetch("t1", 8'h10, 4);

    // 2: back-to-back dependency costs two bubbles
    put(8'h00, ins(4'h0, 4'd1, 4'd2, 4'd3, 8'h01));
    put(8'h01, ins(4'h0, 4'd4, 4'd1, 4'd1, 8'h02));
    put(8'h02, 24'hF00000);
    run("t2", 8'h00, 2, 1'b0);
    check("t2_gap", last_cyc - first_cyc, 3);

    // 3: nega ignores rs2
    put(8'h50, ins(4'h0, 4'd6, 4'd0, 4'd0, 8'h05));
    put(8'h51, ins(4'h2, 4'd5, 4'd2, 4'd6, 8'h06));
    put(8'h52, 24'hF00000);
    run("t3", 8'h50, 0, 1'b0);
    check("t3_gap", last_cyc - first_cyc, 1);

    // 7: one independent instruction between producer and rs2 consumer
    put(8'h60, ins(4'h0, 4'd1, 4'd2, 4'd3, 8'h00));
    put(8'h61, ins(4'h0, 4'd9, 4'd0, 4'd0, 8'h00));
    put(8'h62, ins(4'h1, 4'd3, 4'd0, 4'd1, 8'h00));
    put(8'h63, 24'hF00000);
    run("t7", 8'h60, 1, 1'b0);
    check("t7_gap", last_cyc - first_cyc, 3);

    // 4: pc wraps FF -> 00
    put(8'hFE, ins(4'h0, 4'd8, 4'd0, 4'd1, 8'hAA));
    put(8'hFF, ins(4'h1, 4'd9, 4'd2, 4'd3, 8'hBB));
    put(8'h00, ins(4'h5, 4'd10, 4'd4, 4'd5, 8'hCC));
    put(8'h01, 24'hF00000);
    run("t4", 8'hFE, 0, 1'b0);
    check_fetch("t4", 8'hFE, 4);

    // 5: reset while stalled, then a clean rerun
    put(8'h30, ins(4'h0, 4'd1, 4'd2, 4'd3, 8'h01));
    put(8'h31, ins(4'h0, 4'd4, 4'd1, 4'd1, 8'h02));
    put(8'h32, 24'hF00000);
    done_cnt = 0; first_cyc = -1;
    @(posedge clk); #1; start = 1'b1; base_addr = 8'h30;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 20 && stall_cnt == 8'h00; i++) @(negedge clk);
    check("t5_in_stall", {24'h0, stall_cnt}, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_ctl", {28'h0, issue_valid, busy, done, imem_rd}, 0);
    check("t5_rst_data", {16'h0, imem_addr, stall_cnt}, 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_done", done_cnt, 0);
    exp_q.delete();
    put(8'h30, ins(4'h0, 4'd1, 4'd2, 4'd3, 8'h01));
    put(8'h31, ins(4'h0, 4'd4, 4'd1, 4'd1, 8'h02));
    put(8'h32, 24'hF00000);
    run("t5", 8'h30, 2, 1'b0);

    // 6: start mid-run is ignored
    for (int i = 0; i < 6; i++)
      put(8'h20 + 8'(i), ins(4'h0, 4'd8 + 4'(i), 4'd0, 4'd1, 8'(i)));
    put(8'h26, 24'hF00000);
    mem[8'h40] = 24'hF00000;
    run("t6", 8'h20, 0, 1'b1);
    check_fetch("t6", 8'h20, 7);

    // 8: no halt anywhere; 256 words fetched from 0x80, run ends at wrap
    for (int i = 0; i < 256; i++)
      put(8'h80 + 8'(i), ins(4'($urandom_range(0, 14)), 4'($urandom_range(8, 15)),
                            4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                            8'($urandom_range(0, 255))));
    run("t8", 8'h80, 0, 1'b0);
    check("t8_nfetch", fetch_log.size(), 256);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
